fir_filter_mc: RTL
==================

# fir_filter_mc

Parametrised, multi-channel, time-multiplexed FIR filter for potentiometer and motor-current feedback, driven from the ADC clock domain. One set of shared coefficients; one signed MAC services every channel in turn. Coefficients reload over a streaming handshake with double buffering, so the active set changes atomically between sample frames. Replaces the fixed 4-axis vendor FIR core with native RTL that supports any channel count and tap count, plus a bypass mode.

## Interface
- NCH, 4, number of channels
- NTAPS, 16, taps per channel (≥2)
- DW, 16, signed sample/output width
- CW, 16, signed coefficient width
- OSHIFT, 14, output scaling shift (coefficients are Q(CW-OSHIFT).OSHIFT)
- ACCW, DW+CW+clog2(NTAPS), accumulator width (derived, not overridable)

- clkfir  in  1  filter clock (ADC clock)
- rstn  in  1  asynchronous active-low reset
- data_ready  in  1  one-cycle strobe: din holds a new frame
- din  in  NCH*DW  channel k at [k*DW +: DW], signed
- bypass  in  1  1 = pass samples through unfiltered
- reload_valid  in  1  coefficient word valid
- reload_ready  out  1  coefficient word accepted when valid&ready
- reload_last  in  1  marks final coefficient word (tap NTAPS-1)
- reload_coeff  in  CW  coefficient, tap 0 first
- reload_err  out  1  one-cycle pulse: reload framing error
- dout  out  NCH*DW  filtered outputs, same packing as din
- dout_valid  out  1  one-cycle pulse: all of dout updated
- overrun  out  1  one-cycle pulse: data_ready dropped

## Operation
- States: IDLE, COMPUTE, RELOAD, FLUSH.
- Reset: dout=0, dout_valid=0, overrun=0, reload_err=0, state IDLE, sample history all 0. Active coefficient bank = unity: c[0]=2^OSHIFT, all others 0. Write pointer=0.
- IDLE, data_ready=1, bypass=0: write din into each channel's circular history at wptr, then go to COMPUTE. For each channel 0..NCH-1, MAC y = Σ c[i]·x[n-i] for i=0..NTAPS-1 (signed, full ACCW precision, no intermediate overflow).
- Output conversion per channel: add 2^(OSHIFT-1), arithmetic shift right OSHIFT, saturate to [-2^(DW-1), 2^(DW-1)-1]. Results are staged; all NCH dout lanes update on the same edge that raises dout_valid.
- IDLE, data_ready=1, bypass=1: dout=din and dout_valid pulse on the next edge. History is still written, so switching back to filtering has continuous history.
- data_ready in COMPUTE, RELOAD or FLUSH: frame dropped, overrun pulses next cycle, no other state change.
- reload_ready=1 only in IDLE (when data_ready=0), RELOAD and FLUSH. data_ready has priority over reload_valid in IDLE.
- A handshake in IDLE enters RELOAD. Words go to the shadow bank at index 0,1,…
- Handshake with reload_last at index NTAPS-1: shadow becomes active on the next edge, return to IDLE.
- Handshake with reload_last at index < NTAPS-1: unexpected last. Discard the shadow bank, pulse reload_err, return to IDLE.
- Handshake at index NTAPS-1 without reload_last: missing last. Discard the shadow bank, pulse reload_err, go to FLUSH.
- FLUSH: accept and drop words until a handshake with reload_last, then return to IDLE.
- The active bank is never partially written.

## Timing
- Frame accepted at edge E0. MAC schedule: read (1 cycle), multiply register (1), accumulate (1). Channel k's last product enters the accumulator at E0+(k+1)·NTAPS+2.
- dout/dout_valid update at E0+NCH·NTAPS+3. This is 67 cycles at defaults.
- Return to IDLE on the same edge as dout_valid. A data_ready on that cycle is accepted.
- Minimum frame period is NCH·NTAPS+3 cycles. Bypass latency is 1 cycle.
- reload_err and overrun are single-cycle registered pulses, one cycle after the causing edge.
- Reset assertion mid-COMPUTE or mid-RELOAD: immediate return to reset values. The shadow bank is discarded and the active bank reverts to unity.
- wptr wraps NTAPS-1→0. Tap i addresses (wptr_frame − i) mod NTAPS.

## Test plan
- After reset, frame din={100,-200,32767,-32768}, bypass=0 -> dout_valid at E0+67, dout equals din exactly (unity coefficients).
- Reload c=[8192,8192,0…] with last on word 16, then frames 1000 then 3000 on all channels -> outputs 500 then 2000 (rounded half-sum).
- Reload with last on word 5 -> reload_err pulse, old coefficients still in effect. Reload 17 words with last on word 17 -> err after word 16, words 17 dropped, IDLE after word 17.
- data_ready at E0+10 during COMPUTE -> overrun pulse at E0+11. The single dout_valid at E0+67 reflects the first frame only.
- All coeffs 16384 and input 32767 -> dout saturates to 32767. Same with input −32768 -> dout −32768.
- Assert rstn low at E0+30 -> dout=0 with no dout_valid. A new frame after release filters with unity coefficients and zero history.

Source files
------------

// File: rtl/fir_filter_mc.sv
// fir_filter_mc: time-multiplexed multi-channel FIR with one shared MAC and double-buffered coefficient reload.
module fir_filter_mc #(
    parameter int NCH    = 4,
    parameter int NTAPS  = 16,
    parameter int DW     = 16,
    parameter int CW     = 16,
    parameter int OSHIFT = 14
) (
    input  logic              clkfir,
    input  logic              rstn,
    input  logic              data_ready,
    input  logic [NCH*DW-1:0] din,
    input  logic              bypass,
    input  logic              reload_valid,
    output logic              reload_ready,
    input  logic              reload_last,
    input  logic [CW-1:0]     reload_coeff,
    output logic              reload_err,
    output logic [NCH*DW-1:0] dout,
    output logic              dout_valid,
    output logic              overrun
);
    localparam int ACCW = DW + CW + $clog2(NTAPS);
    localparam int TW   = $clog2(NTAPS);
    localparam int CHW  = NCH > 1 ? $clog2(NCH) : 1;
    localparam logic [1:0] IDLE = 2'd0, COMPUTE = 2'd1, RELOAD = 2'd2, FLUSH = 2'd3;
    localparam logic signed [CW-1:0] ONE   = CW'(1 << OSHIFT);
    localparam logic signed [ACCW:0] HALF  = (ACCW + 1)'(1) << (OSHIFT - 1);
    localparam logic signed [ACCW:0] SMAX  = {{(ACCW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [ACCW:0] SMIN  = ~SMAX;

    logic [1:0] state;
    logic signed [DW-1:0] hist [NCH][NTAPS];
    logic signed [CW-1:0] coef [NTAPS];
    logic signed [CW-1:0] shadow [NTAPS];
    logic signed [DW-1:0] stage [NCH];
    logic [TW-1:0] wptr, wf, tap_i, ridx, raddr;
    logic [CHW-1:0] ch_i, ch1, ch2;
    logic iss, v1, f1, l1, v2, f2, l2, done;
    logic signed [DW-1:0] x1;
    logic signed [CW-1:0] c1;
    logic signed [DW+CW-1:0] prod;
    logic signed [ACCW-1:0] acc, acc_nx, pext;
    logic signed [ACCW:0] rnd, shf;
    logic signed [DW-1:0] sat;
    logic take, hs;

    always_comb begin
        raddr = TW'((int'(wf) + NTAPS - int'(tap_i)) % NTAPS);
        pext = {{(ACCW - DW - CW){prod[DW+CW-1]}}, prod};
        acc_nx = f2 ? pext : acc + pext;
        rnd = {acc_nx[ACCW-1], acc_nx} + HALF;
        shf = rnd >>> OSHIFT;
        sat = shf > SMAX ? DW'(SMAX) : shf < SMIN ? DW'(SMIN) : shf[DW-1:0];
        // a frame arriving on the result edge is taken immediately, keeping the frame period at NCH*NTAPS+3
        take = data_ready && (state == IDLE || (done && !bypass));
        reload_ready = (state == IDLE && !data_ready) || state == RELOAD || state == FLUSH;
        hs = reload_valid && reload_ready;
    end

    always_ff @(posedge clkfir or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            wptr <= '0;
            wf <= '0;
            tap_i <= '0;
            ch_i <= '0;
            ridx <= '0;
            iss <= 1'b0;
            v1 <= 1'b0;
            f1 <= 1'b0;
            l1 <= 1'b0;
            ch1 <= '0;
            v2 <= 1'b0;
            f2 <= 1'b0;
            l2 <= 1'b0;
            ch2 <= '0;
            done <= 1'b0;
            x1 <= '0;
            c1 <= '0;
            prod <= '0;
            acc <= '0;
            dout <= '0;
            dout_valid <= 1'b0;
            overrun <= 1'b0;
            reload_err <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                stage[k] <= '0;
                for (int i = 0; i < NTAPS; i++) hist[k][i] <= '0;
            end
            for (int i = 0; i < NTAPS; i++) begin
                coef[i] <= i == 0 ? ONE : '0;
                shadow[i] <= '0;
            end
        end else begin
            dout_valid <= 1'b0;
            reload_err <= 1'b0;
            overrun <= data_ready && !take;
            v1 <= iss;
            x1 <= hist[ch_i][raddr];
            c1 <= coef[tap_i];
            f1 <= tap_i == '0;
            l1 <= tap_i == TW'(NTAPS - 1);
            ch1 <= ch_i;
            v2 <= v1;
            prod <= x1 * c1;
            f2 <= f1;
            l2 <= l1;
            ch2 <= ch1;
            if (v2) acc <= acc_nx;
            if (v2 && l2) stage[ch2] <= sat;
            done <= v2 && l2 && ch2 == CHW'(NCH - 1);
            if (iss) begin
                tap_i <= tap_i == TW'(NTAPS - 1) ? '0 : tap_i + 1'b1;
                if (tap_i == TW'(NTAPS - 1)) begin
                    iss <= ch_i != CHW'(NCH - 1);
                    ch_i <= ch_i + 1'b1;
                end
            end
            if (done) begin
                for (int k = 0; k < NCH; k++) dout[k*DW +: DW] <= stage[k];
                dout_valid <= 1'b1;
                state <= IDLE;
            end
            if (take) begin
                for (int k = 0; k < NCH; k++) hist[k][wptr] <= din[k*DW +: DW];
                wf <= wptr;
                wptr <= wptr == TW'(NTAPS - 1) ? '0 : wptr + 1'b1;
                if (bypass) begin
                    dout <= din;
                    dout_valid <= 1'b1;
                end else begin
                    state <= COMPUTE;
                    iss <= 1'b1;
                    tap_i <= '0;
                    ch_i <= '0;
                end
            end else if (hs && state == FLUSH) begin
                if (reload_last) state <= IDLE;
            end else if (hs) begin
                shadow[ridx] <= reload_coeff;
                ridx <= '0;
                if (reload_last && ridx == TW'(NTAPS - 1)) begin
                    for (int i = 0; i < NTAPS; i++) coef[i] <= i == NTAPS - 1 ? reload_coeff : shadow[i];
                    state <= IDLE;
                end else if (reload_last) begin
                    reload_err <= 1'b1;
                    state <= IDLE;
                end else if (ridx == TW'(NTAPS - 1)) begin
                    reload_err <= 1'b1;
                    state <= FLUSH;
                end else begin
                    ridx <= ridx + 1'b1;
                    state <= RELOAD;
                end
            end
        end
    end
endmodule
